// File: rtl/zapper_hit_detect_if.sv
// zapper_hit_detect_if: gun inputs, vga position and pattern_gen/game-facing outputs of the hit detector
interface zapper_hit_detect_if;
  logic       trigger;
  logic       light;
  logic [9:0] row_count;
  logic [9:0] col_count;
  logic       valid;
  logic       blank_req;
  logic       target_req;
  logic       hit;
  logic       miss;
  logic       busy;
  modport master (
    output trigger, light, row_count, col_count, valid,
    input  blank_req, target_req, hit, miss, busy
  );
  modport slave (
    input  trigger, light, row_count, col_count, valid,
    output blank_req, target_req, hit, miss, busy
  );
endinterface

// File: rtl/zapper_hit_detect.sv
// zapper_hit_detect: light-gun two-frame flash sequencer (dark anti-cheat frame, then lit target frame)
module zapper_hit_detect #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HIT_THRESHOLD   = 64,
  parameter int DARK_TOLERANCE  = 16,
  parameter int CNT_W           = 16
) (
  input logic clk,
  input logic reset,
  zapper_hit_detect_if.slave bus
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, ARM, DARK, LIT, RESULT, COOLDOWN} state_t;
  state_t state, state_nx;
  logic [1:0] trig_s, light_s;
  logic db;
  logic [DB_W-1:0] db_cnt;
  logic [CNT_W-1:0] dark_cnt, lit_cnt, lit_nx;
  logic verdict, verdict_nx, clr, press, frame_start, lit_px, db_done;
  assign db_done     = db_cnt == DB_W'(DEBOUNCE_CYCLES - 1);
  assign press       = trig_s[1] & ~db & db_done;
  assign frame_start = bus.row_count == 10'd0 && bus.col_count == 10'd0;
  assign lit_px      = bus.valid & light_s[1];
  assign lit_nx      = lit_cnt + CNT_W'(lit_px && !(&lit_cnt));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_s  <= '0;
      light_s <= '0;
      db      <= 1'b0;
      db_cnt  <= '0;
    end else begin
      trig_s  <= {trig_s[0], bus.trigger};
      light_s <= {light_s[0], bus.light};
      db      <= (trig_s[1] != db && db_done) ? ~db : db;
      db_cnt  <= (trig_s[1] == db || db_done) ? '0 : db_cnt + DB_W'(1);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      verdict  <= 1'b0;
      dark_cnt <= '0;
      lit_cnt  <= '0;
    end else begin
      state    <= state_nx;
      verdict  <= verdict_nx;
      dark_cnt <= clr ? '0 : dark_cnt + CNT_W'(state == DARK && lit_px && !(&dark_cnt));
      lit_cnt  <= clr ? '0 : (state == LIT ? lit_nx : lit_cnt);
    end
  end
  // LIT verdict uses lit_nx so the frame_start cycle's own sample is included
  always_comb begin
    state_nx   = state;
    verdict_nx = verdict;
    clr        = 1'b0;
    case (state)
      IDLE:     state_nx = press ? ARM : IDLE;
      ARM: if (frame_start) begin
        state_nx = DARK;
        clr      = 1'b1;
      end
      DARK: if (frame_start) begin
        state_nx   = dark_cnt > CNT_W'(DARK_TOLERANCE) ? RESULT : LIT;
        verdict_nx = 1'b0;
      end
      LIT: if (frame_start) begin
        state_nx   = RESULT;
        verdict_nx = lit_nx >= CNT_W'(HIT_THRESHOLD);
      end
      RESULT:   state_nx = COOLDOWN;
      COOLDOWN: state_nx = db ? COOLDOWN : IDLE;
      default:  state_nx = IDLE;
    endcase
  end
  assign bus.blank_req  = state == DARK;
  assign bus.target_req = state == LIT;
  assign bus.hit        = state == RESULT && verdict;
  assign bus.miss       = state == RESULT && !verdict;
  assign bus.busy       = state != IDLE;
endmodule

// File: tb/tb_zapper_hit_detect.sv
// tb_zapper_hit_detect: directed bench on a shrunken 20x10 frame (16x8 active) with DEBOUNCE_CYCLES=4
module tb_zapper_hit_detect;
  localparam int FW = 20, FH = 10, VW = 16, VH = 8, FR = FW * FH;
  logic clk = 1'b0;
  logic reset;
  int pos, n_now, n_next, n_chk, n_pass;
  bit saw_t, saw_hm;
  zapper_hit_detect_if bus();
  zapper_hit_detect #(.DEBOUNCE_CYCLES(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #20 clk = ~clk;
  // light is driven two pixels ahead to cancel the synchronizer delay; lit pixels start at active index 16
  function automatic logic lit_at(int p);
    int r, c, idx;
    r = p / FW;
    c = p % FW;
    idx = r * VW + c;
    return c < VW && r < VH && idx >= 16 && idx < 16 + n_now;
  endfunction
  task automatic drive();
    bus.row_count = 10'(pos / FW);
    bus.col_count = 10'(pos % FW);
    bus.valid     = (pos % FW) < VW && (pos / FW) < VH;
    bus.light     = lit_at((pos + 2) % FR);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    pos = (pos + 1) % FR;
    if (pos == 0) begin
      n_now  = n_next;
      n_next = 0;
    end
    drive();
    if (bus.target_req) saw_t = 1;
    if (bus.hit | bus.miss) saw_hm = 1;
  endtask
  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic wait_blank(string tag);
    int k;
    for (k = 0; k < 500 && !bus.blank_req; k++) tick();
    chk({tag, "_blank_start"}, 8'(bus.blank_req), 8'd1);
  endtask
  task automatic shot(string tag, int nd, int nl, bit exp_lit, bit exp_hit);
    bus.trigger = 1'b1;
    n_now = 0;
    n_next = 0;
    wait_blank(tag);
    n_now = nd;
    n_next = nl;
    saw_t = 0;
    repeat (FR - 1) tick();
    chk({tag, "_dark_hold"}, {6'd0, bus.blank_req, bus.target_req}, 8'b10);
    tick();
    if (exp_lit) begin
      chk({tag, "_lit_enter"}, {6'd0, bus.blank_req, bus.target_req}, 8'b01);
      repeat (FR - 1) tick();
      chk({tag, "_lit_hold"}, {6'd0, bus.blank_req, bus.target_req}, 8'b01);
      tick();
    end
    chk({tag, "_result"}, {4'd0, bus.hit, bus.miss, bus.blank_req, bus.target_req},
        {4'd0, exp_hit, !exp_hit, 2'b00});
    if (!exp_lit) chk({tag, "_no_target"}, 8'(saw_t), 8'd0);
    tick();
    chk({tag, "_cooldown"}, {5'd0, bus.hit, bus.miss, bus.busy}, 8'b001);
  endtask
  task automatic release_trigger(string tag);
    bus.trigger = 1'b0;
    repeat (6) tick();
    chk({tag, "_still_busy"}, 8'(bus.busy), 8'd1);
    tick();
    chk({tag, "_idle"}, 8'(bus.busy), 8'd0);
  endtask
  initial begin
    n_chk = 0;
    n_pass = 0;
    pos = 0;
    n_now = 0;
    n_next = 0;
    reset = 1'b1;
    bus.trigger = 1'b0;
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {3'd0, bus.blank_req, bus.target_req, bus.hit, bus.miss, bus.busy}, 8'd0);
    reset = 1'b0;
    repeat (3) tick();
    bus.trigger = 1'b1;
    repeat (3) tick();
    bus.trigger = 1'b0;
    saw_hm = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.busy) saw_hm = 1;
    end
    chk("glitch_no_press", 8'(saw_hm), 8'd0);
    bus.trigger = 1'b1;
    repeat (5) tick();
    chk("debounce_not_yet", 8'(bus.busy), 8'd0);
    tick();
    chk("debounce_press", 8'(bus.busy), 8'd1);
    shot("dark_only", 0, 0, 1, 0);
    bus.trigger = 1'b0;
    repeat (2) tick();
    bus.trigger = 1'b1;
    repeat (300) tick();
    chk("held_no_rearm", {6'd0, bus.busy, bus.blank_req}, 8'b10);
    release_trigger("rel1");
    shot("hit100", 0, 100, 1, 1);
    release_trigger("rel2");
    shot("miss63", 0, 63, 1, 0);
    release_trigger("rel3");
    shot("hit64", 0, 64, 1, 1);
    release_trigger("rel4");
    shot("dark17", 17, 0, 0, 0);
    release_trigger("rel5");
    shot("dark16", 16, 0, 1, 0);
    release_trigger("rel6");
    bus.trigger = 1'b1;
    wait_blank("midlit");
    n_next = 100;
    repeat (FR) tick();
    chk("midlit_in_lit", 8'(bus.target_req), 8'd1);
    repeat (50) tick();
    #3;
    reset = 1'b1;
    #1;
    chk("midlit_reset_drop", {3'd0, bus.blank_req, bus.target_req, bus.hit, bus.miss, bus.busy}, 8'd0);
    bus.trigger = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    saw_hm = 0;
    repeat (2 * FR) tick();
    chk("midlit_no_pulse", {6'd0, saw_hm, bus.busy}, 8'd0);
    shot("post_reset", 0, 100, 1, 1);
    release_trigger("rel7");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/zapper_hit_detect.md
Name: zapper_hit_detect

Overview:
- Input-side counterpart of the VGA video path: reads the light-gun trigger and photodiode and decides hit or miss on the current target.
- Runs the classic two-frame flash sequence. The first frame is forced black to catch cheating; the second frame draws only the target box white.
- Sits beside pattern_gen on the 25 MHz pixel clock, consuming the vga row/col counters. It drives pattern_gen's override requests and feeds hit/miss pulses to the game logic.

Parameters:
- DEBOUNCE_CYCLES, 250000, cycles trigger must hold a new level before it is accepted (10 ms at 25 MHz).
- HIT_THRESHOLD, 64, minimum lit-frame light cycles for a hit.
- DARK_TOLERANCE, 16, maximum dark-frame light cycles tolerated before an automatic miss.
- CNT_W, 16, width of the light counters; counters saturate at all-ones.

Ports:
- clk  in  1  pixel clock, 25 MHz
- reset  in  1  asynchronous active-high reset
- trigger  in  1  raw gun trigger, asynchronous, 1 = pulled
- light  in  1  raw photodiode comparator, asynchronous, 1 = light seen
- row_count  in  10  current vga row
- col_count  in  10  current vga column
- valid  in  1  vga active-video flag
- blank_req  out  1  request pattern_gen to output black for the whole frame
- target_req  out  1  request pattern_gen to draw only the target box white
- hit  out  1  one-cycle pulse, shot hit
- miss  out  1  one-cycle pulse, shot missed
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset, asynchronous: state=IDLE, synchronizers cleared, debounced trigger=0, counters=0, all outputs 0.
- Synchronizers: trigger and light each pass through 2 flops before use. Total input latency is 2 cycles.
- Debounce:
  - Counter resets whenever the synced trigger equals the debounced value.
  - Otherwise the counter increments; at DEBOUNCE_CYCLES-1 the debounced value flips.
  - A press is a 0->1 edge of the debounced trigger.
- frame_start: asserted for the single cycle where row_count==0 and col_count==0.
- FSM states:
  - IDLE: on a press, go to ARM. Presses in any other state are ignored.
  - ARM: wait for frame_start. On frame_start go to DARK, clear both counters, and assert blank_req that same cycle.
  - DARK: blank_req=1. Increment dark_cnt on each cycle with valid && synced light. On the next frame_start:
    - if dark_cnt > DARK_TOLERANCE, go to RESULT with verdict miss;
    - otherwise go to LIT and assert target_req.
  - LIT: target_req=1. Increment lit_cnt on valid && synced light. On the next frame_start go to RESULT with verdict = (lit_cnt >= HIT_THRESHOLD). Use the count including the frame_start cycle's own sample.
  - RESULT: one cycle. Pulse hit or miss (never both). Go to COOLDOWN.
  - COOLDOWN: wait until debounced trigger==0, then IDLE. This enforces one shot per pull.
- Request timing: blank_req and target_req are registered and change only on frame_start cycles. They are never both 1.
- Counters saturate at 2^CNT_W-1 and never wrap.
- busy = (state != IDLE).
- Reset mid-sequence: everything returns to IDLE immediately. No hit/miss pulse is produced and requests drop asynchronously.
- Light outside valid (blanking) is ignored in all states.

Test Plan:
- DEBOUNCE_CYCLES=4. Trigger glitch high for 3 cycles -> no press, busy stays 0. Trigger held 10 cycles -> busy rises 2+4 cycles after the edge.
- Press, light held 0 for the whole sequence -> blank_req for exactly 1 frame (420000 cycles at 800x525), then target_req for 1 frame, then miss pulse 1 cycle, hit=0.
- Press, light=1 for 100 valid cycles in the LIT frame only -> hit pulse 1 cycle at the second frame_start after DARK entry, plus 1. Repeat with 63 cycles -> miss.
- Press, light=1 for 17 valid cycles during DARK -> miss at the end of DARK, target_req never asserted. With 16 cycles -> proceeds to LIT.
- Trigger held after the result, then a second pull attempt without release -> no new sequence. Release then press -> new sequence starts.
- Assert reset mid-LIT -> blank_req, target_req and busy drop to 0 immediately, no hit/miss pulse; a normal sequence after reset completes correctly.
